sdram_xfer_sched: RTL



---
 rtl/sdram_xfer_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sdram_xfer_sched.sv
// sdram_xfer_sched: decides when to fire sdram_top write/read blocks.
// Writes are gated by write-FIFO fill and ring occupancy, reads by read-FIFO
// free space and resident blocks; one block in flight at a time, completion
// is detected by counting the FIFO strobes of the active direction.
// Optional watchdog: define SCHED_WDOG_EN to add the timeout/ERR state.
module sdram_xfer_sched #(
  parameter int CNT_W      = 10,
  parameter int FIFO_DEPTH = 512,
  parameter int XFER_WORDS = 256,
  parameter int WR_THRESH  = 256,
  parameter int RD_SPACE   = 256,
  parameter int MAX_BLK    = 16,
  parameter int TMO_CYC    = 4096
) (
  input  logic                     sclk,
  input  logic                     s_rst_n,
  input  logic                     sched_en,
  input  logic [CNT_W-1:0]         wfifo_count,
  input  logic [CNT_W-1:0]         rfifo_count,
  input  logic                     wfifo_rd_en,
  input  logic                     rfifo_wr_en,
  input  logic                     clr_err,
  output logic                     wr_trig,
  output logic                     rd_trig,
  output logic                     busy,
  output logic [$clog2(MAX_BLK):0] pend_blk,
  output logic                     err
);
  localparam int PB_W = $clog2(MAX_BLK) + 1;
  localparam int XC_W = $clog2(XFER_WORDS) + 1;
  localparam int LW   = CNT_W + 2;

`ifdef SCHED_WDOG_EN
  typedef enum logic [2:0] {IDLE, WR_TRIG, WR_WAIT, RD_TRIG, RD_WAIT, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR_TRIG, WR_WAIT, RD_TRIG, RD_WAIT} state_t;
`endif

  state_t          state, state_n;
  logic [XC_W-1:0] cnt;
  logic            last_wr;
  logic            wr_elig, rd_elig, in_wr, in_rd, stb, blk_done;

  // Free space test is written as an addition so a count above depth
  // cannot wrap into a false "plenty of room".
  assign wr_elig = ({2'b00, wfifo_count} >= LW'(WR_THRESH)) && (pend_blk < PB_W'(MAX_BLK));
  assign rd_elig = (({2'b00, rfifo_count} + LW'(RD_SPACE)) <= LW'(FIFO_DEPTH)) && (pend_blk != '0);

  assign in_wr    = (state == WR_TRIG) || (state == WR_WAIT);
  assign in_rd    = (state == RD_TRIG) || (state == RD_WAIT);
  assign stb      = (in_wr && wfifo_rd_en) || (in_rd && rfifo_wr_en);
  assign blk_done = stb && (cnt == XC_W'(XFER_WORDS - 1));

`ifdef SCHED_WDOG_EN
  localparam int TMR_W = $clog2(TMO_CYC) + 1;
  logic [TMR_W-1:0] tmr;
  logic             tmo;
  assign tmo = (tmr == TMR_W'(TMO_CYC - 1));

  // Watchdog: counts every cycle a block is outstanding, zero otherwise
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n)           tmr <= '0;
    else if (in_wr || in_rd) tmr <= tmr + 1'b1;
    else                    tmr <= '0;

  // Sticky error follows residence in ERR
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) err <= 1'b0;
    else          err <= (state_n == ERR);
`else
  localparam int tmo_cyc_unused = TMO_CYC;
  logic clr_err_unused;
  assign clr_err_unused = clr_err;
  assign err = 1'b0;
`endif

  // Next state: arbitrate in IDLE, track completion otherwise
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (sched_en) begin
        if (wr_elig && (!rd_elig || !last_wr)) state_n = WR_TRIG;
        else if (rd_elig)                      state_n = RD_TRIG;
      end
      WR_TRIG, WR_WAIT: state_n = blk_done ? IDLE : WR_WAIT;
      RD_TRIG, RD_WAIT: state_n = blk_done ? IDLE : RD_WAIT;
`ifdef SCHED_WDOG_EN
      ERR: if (clr_err) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
`ifdef SCHED_WDOG_EN
    if ((in_wr || in_rd) && !blk_done && tmo) state_n = ERR;
`endif
  end

  // State register
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) state <= IDLE;
    else          state <= state_n;

  // Registered outputs decoded from the upcoming state
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      wr_trig <= 1'b0;
      rd_trig <= 1'b0;
      busy    <= 1'b0;
    end else begin
      wr_trig <= (state_n == WR_TRIG);
      rd_trig <= (state_n == RD_TRIG);
      busy    <= (state_n != IDLE);
    end

  // Strobe counter for the active direction
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n)  cnt <= '0;
    else if (stb)  cnt <= blk_done ? '0 : cnt + 1'b1;
`ifdef SCHED_WDOG_EN
    else if ((state == ERR) && clr_err) cnt <= '0;
`endif

  // Ring occupancy and round-robin history, updated at block completion
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      pend_blk <= '0;
      last_wr  <= 1'b0;
    end else if (blk_done) begin
      if (in_wr) begin
        pend_blk <= pend_blk + 1'b1;
        last_wr  <= 1'b1;
      end else begin
        pend_blk <= pend_blk - 1'b1;
        last_wr  <= 1'b0;
      end
    end
endmodule
